// File: rtl/spi_host_param.sv
// ============================================================================
//  Module   : spi_host_param
//  Purpose  : Parameterisable single-word SPI host for OLED-style peripherals.
//             Runs one transfer of DATA_W bits per accepted request, with
//             selectable clock polarity, clock phase and bit order, plus a
//             registered data/command flag.
//  Ports    : clk_i        - clock, all logic on rising edge
//             rst_ni       - asynchronous active-low reset
//             start_i      - transfer request (accepted when ready_o=1)
//             data_i       - payload, captured at accept
//             dc_i         - data/command flag, captured at accept
//             cpol_i       - clock polarity, captured at accept (live in IDLE)
//             cpha_i       - clock phase, captured at accept
//             lsb_first_i  - 1 = LSB first, captured at accept
//             ready_o      - high only while idle
//             done_o       - one-cycle pulse in the first idle cycle
//             ncs_o        - chip select, active low
//             sclk_o       - serial clock
//             sdo_o        - serial data out
//             dc_o         - captured data/command flag
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_host_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 10,
    parameter int CS_HOLD = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              dc_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              ncs_o,
    output logic              sclk_o,
    output logic              sdo_o,
    output logic              dc_o
);

    localparam int c_half_int = CLK_DIV / 2;
    localparam int c_cnt_max  = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
    localparam int CW         = $clog2(c_cnt_max + 1);
    localparam int BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] c_cnt_one     = CW'(1);
    localparam logic [CW-1:0] c_half        = CW'(c_half_int);
    localparam logic [CW-1:0] c_half_last   = CW'(c_half_int - 1);
    localparam logic [CW-1:0] c_period_last = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_hold_last   = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] c_bit_one     = BW'(1);
    localparam logic [BW-1:0] c_bit_last    = BW'(DATA_W - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_SHIFT  = 2'd2;
    localparam logic [1:0] c_HOLDCS = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_cpol, r_cpha, r_lsb, r_dc;
    logic              r_done, r_ncs, r_sclk, r_sdo;

    logic [1:0]        w_state_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [BW-1:0]     w_bit_nx;
    logic [DATA_W-1:0] w_shift_nx;
    logic              w_cpol_nx, w_cpha_nx, w_lsb_nx, w_dc_nx, w_done_nx;
    logic              w_sclk_nx, w_sdo_nx;

    // Next-state and counter logic. Counters restart at 0 on every phase
    // change so each phase lasts exactly its terminal count + 1 cycles.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_cpol_nx  = r_cpol;
        w_cpha_nx  = r_cpha;
        w_lsb_nx   = r_lsb;
        w_dc_nx    = r_dc;
        w_done_nx  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_nx = c_SETUP;
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                    w_shift_nx = data_i;
                    w_cpol_nx  = cpol_i;
                    w_cpha_nx  = cpha_i;
                    w_lsb_nx   = lsb_first_i;
                    w_dc_nx    = dc_i;
                end
            end
            c_SETUP: begin
                if (r_cnt == c_half_last) begin
                    w_state_nx = c_SHIFT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            c_SHIFT: begin
                if (r_cnt == c_period_last) begin
                    w_cnt_nx = '0;
                    if (r_bit == c_bit_last) begin
                        w_state_nx = c_HOLDCS;
                        w_bit_nx   = '0;
                    end else begin
                        w_bit_nx   = r_bit + c_bit_one;
                        w_shift_nx = r_lsb ? (r_shift >> 1) : (r_shift << 1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            default: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
        endcase
    end

    // Output values are derived from the next state so the registered
    // outputs line up with the state they belong to. In SHIFT the first half
    // of a bit period is at cpol (cpha=0) or ~cpol (cpha=1).
    always_comb begin
        w_sclk_nx = w_cpol_nx;
        w_sdo_nx  = 1'b1;
        if (w_state_nx == c_SHIFT) begin
            w_sclk_nx = w_cpol_nx ^ ((w_cnt_nx < c_half) ? w_cpha_nx : ~w_cpha_nx);
        end
        if ((w_state_nx == c_SETUP) || (w_state_nx == c_SHIFT)) begin
            w_sdo_nx = w_lsb_nx ? w_shift_nx[0] : w_shift_nx[DATA_W-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_dc    <= 1'b0;
            r_done  <= 1'b0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_cpol  <= w_cpol_nx;
            r_cpha  <= w_cpha_nx;
            r_lsb   <= w_lsb_nx;
            r_dc    <= w_dc_nx;
            r_done  <= w_done_nx;
            r_ncs   <= (w_state_nx == c_IDLE);
            r_sclk  <= w_sclk_nx;
            r_sdo   <= w_sdo_nx;
        end
    end

    // While idle the clock follows the live polarity input so the bus
    // already sits at the right level before the next accept.
    assign ready_o = (r_state == c_IDLE);
    assign sclk_o  = (r_state == c_IDLE) ? cpol_i : r_sclk;
    assign done_o  = r_done;
    assign ncs_o   = r_ncs;
    assign sdo_o   = r_sdo;
    assign dc_o    = r_dc;

endmodule

`default_nettype wire

// File: tb/tb_spi_host_param.sv
// ============================================================================
//  Module   : tb_spi_host_param
//  Purpose  : Self-checking bench for spi_host_param. Instance A uses the
//             default parameters, instance B uses DATA_W=16, CLK_DIV=2,
//             CS_HOLD=1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_host_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A (defaults)
    logic       start_a = 1'b0, dc_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0, lsb_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, done_a, ncs_a, sclk_a, sdo_a, dco_a;

    // instance B (wide, fast)
    logic        start_b = 1'b0, dc_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0, lsb_b = 1'b0;
    logic [15:0] data_b = 16'h0000;
    logic        ready_b, done_b, ncs_b, sclk_b, sdo_b, dco_b;

    spi_host_param u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .data_i(data_a),
        .dc_i(dc_a), .cpol_i(cpol_a), .cpha_i(cpha_a), .lsb_first_i(lsb_a),
        .ready_o(ready_a), .done_o(done_a), .ncs_o(ncs_a), .sclk_o(sclk_a),
        .sdo_o(sdo_a), .dc_o(dco_a)
    );

    spi_host_param #(.DATA_W(16), .CLK_DIV(2), .CS_HOLD(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .data_i(data_b),
        .dc_i(dc_b), .cpol_i(cpol_b), .cpha_i(cpha_b), .lsb_first_i(lsb_b),
        .ready_o(ready_b), .done_o(done_b), .ncs_o(ncs_b), .sclk_o(sclk_b),
        .sdo_o(sdo_b), .dc_o(dco_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic [7:0] exp_seq;   // sampled bits, first sample in bit 7
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer on instance A and measures it from the outside.
    // Inputs are scrambled right after accept; an optional start pulse is
    // issued 'poke' cycles into the transfer and must be ignored.
    task automatic run_a(input vec_t v, input int poke,
                         output logic [31:0] seq, output int low, output int rises,
                         output int falls, output int rdy_bad, output logic done_ok,
                         output int extra_low);
        logic prev, samp_lvl, fin, done_first;
        seq = '0; low = 0; rises = 0; falls = 0; rdy_bad = 0; extra_low = 0;
        fin = 1'b0; done_first = 1'b0;
        @(negedge clk);
        data_a = v.data; dc_a = v.dc; cpol_a = v.cpol; cpha_a = v.cpha; lsb_a = v.lsb;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        data_a = ~v.data; dc_a = ~v.dc; cpha_a = ~v.cpha; lsb_a = ~v.lsb;
        samp_lvl = ~(v.cpol ^ v.cpha);
        prev = v.cpol;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (ncs_a == 1'b0) begin
                low++;
                if (ready_a !== 1'b0) rdy_bad++;
                if (sclk_a != prev) begin
                    if (sclk_a) rises++; else falls++;
                    if (sclk_a == samp_lvl) seq = {seq[30:0], sdo_a};
                end
                prev = sclk_a;
                start_a = (poke > 0 && cyc == poke);
                @(negedge clk);
            end else begin
                fin = 1'b1;
                done_first = done_a;
            end
        end
        start_a = 1'b0;
        @(negedge clk);
        done_ok = fin && (done_first === 1'b1) && (done_a === 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (ncs_a !== 1'b1) extra_low++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] seq, seq1, seq2;
        int          low, rises, falls, rdy_bad, extra_low, dones, gap, phase, bad_int, last_rise;
        logic        done_ok, prev, fin, done_seen;

        vecs[0] = '{data: 8'hA5, dc: 1'b1, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, exp_seq: 8'hA5};
        vecs[1] = '{data: 8'h3C, dc: 1'b0, cpol: 1'b1, cpha: 1'b1, lsb: 1'b0, exp_seq: 8'h3C};
        vecs[2] = '{data: 8'h01, dc: 1'b1, cpol: 1'b0, cpha: 1'b0, lsb: 1'b1, exp_seq: 8'h80};
        vecs[3] = '{data: 8'hB2, dc: 1'b0, cpol: 1'b0, cpha: 1'b1, lsb: 1'b1, exp_seq: 8'h4D};
        vecs[4] = '{data: 8'h5A, dc: 1'b1, cpol: 1'b1, cpha: 1'b0, lsb: 1'b0, exp_seq: 8'h5A};

        // reset state, with the idle clock tracking cpol_i live
        cpol_a = 1'b1;
        #22;
        check("rst_ncs", ncs_a, 1);
        check("rst_sdo", sdo_a, 1);
        check("rst_done", done_a, 0);
        check("rst_dc", dco_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_sclk_hi", sclk_a, 1);
        cpol_a = 1'b0;
        #1;
        check("rst_sclk_lo", sclk_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven transfers
        for (int k = 0; k < 5; k++) begin
            run_a(vecs[k], 0, seq, low, rises, falls, rdy_bad, done_ok, extra_low);
            check($sformatf("v%0d_bits", k), seq[7:0], vecs[k].exp_seq);
            check($sformatf("v%0d_ncs_low", k), low, 88);
            check($sformatf("v%0d_rises", k), rises, 8);
            check($sformatf("v%0d_falls", k), falls, 8);
            check($sformatf("v%0d_ready_busy", k), rdy_bad, 0);
            check($sformatf("v%0d_done", k), done_ok, 1);
            check($sformatf("v%0d_dc_o", k), dco_a, vecs[k].dc);
            check($sformatf("v%0d_sclk_idle", k), sclk_a, vecs[k].cpol);
            check($sformatf("v%0d_no_extra", k), extra_low, 0);
        end

        // back-to-back: start held high across two transfers
        @(negedge clk);
        data_a = 8'h11; dc_a = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
        start_a = 1'b1;
        phase = 0; gap = 0; dones = 0; low = 0; seq1 = '0; seq2 = '0; prev = 1'b0;
        for (int cyc = 0; cyc < 230; cyc++) begin
            @(negedge clk);
            if (ncs_a == 1'b0) begin
                low++;
                if (phase == 0) begin phase = 1; data_a = 8'h22; end
                if (phase == 2) begin phase = 3; start_a = 1'b0; end
                if (sclk_a != prev && sclk_a) begin
                    if (phase == 1) seq1 = {seq1[30:0], sdo_a};
                    else            seq2 = {seq2[30:0], sdo_a};
                end
            end else begin
                if (phase == 1) phase = 2;
                if (phase == 2) gap++;
                if (phase == 3) phase = 4;
            end
            prev = sclk_a;
            if (done_a === 1'b1) dones++;
        end
        start_a = 1'b0;
        check("b2b_phase", phase, 4);
        check("b2b_gap", gap, 1);
        check("b2b_dones", dones, 2);
        check("b2b_low", low, 176);
        check("b2b_bits1", seq1[7:0], 8'h11);
        check("b2b_bits2", seq2[7:0], 8'h22);

        // reset 40 cycles into a transfer
        @(negedge clk);
        data_a = 8'h00; dc_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_a === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort_busy", ncs_a, 0);
        rst_n = 1'b0;
        #1;
        check("abort_ncs", ncs_a, 1);
        check("abort_sdo", sdo_a, 1);
        check("abort_dc", dco_a, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) rst_n = 1'b1;
            if (done_a === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_a('{data: 8'hFF, dc: 1'b0, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, exp_seq: 8'hFF},
              30, seq, low, rises, falls, rdy_bad, done_ok, extra_low);
        check("post_rst_bits", seq[7:0], 8'hFF);
        check("post_rst_rises", rises, 8);
        check("post_rst_low", low, 88);
        check("post_rst_done", done_ok, 1);
        check("busy_start_ignored", extra_low, 0);

        // wide, fast instance
        @(negedge clk);
        data_b = 16'h8001; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; data_b = 16'h7FFE;
        seq = '0; low = 0; rises = 0; falls = 0; bad_int = 0; last_rise = -1;
        prev = 1'b0; fin = 1'b0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!fin) begin
                if (ncs_b == 1'b0) begin
                    low++;
                    if (sclk_b != prev) begin
                        if (sclk_b) begin
                            rises++;
                            if (last_rise >= 0 && cyc - last_rise != 2) bad_int++;
                            last_rise = cyc;
                            seq = {seq[30:0], sdo_b};
                        end else begin
                            falls++;
                        end
                    end
                    prev = sclk_b;
                end else begin
                    fin = 1'b1;
                    done_seen = (done_b === 1'b1);
                end
            end
            @(negedge clk);
        end
        check("w_bits", seq[15:0], 16'h8001);
        check("w_ncs_low", low, 34);
        check("w_rises", rises, 16);
        check("w_falls", falls, 16);
        check("w_period", bad_int, 0);
        check("w_done", done_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_host_param.md
SPI_HOST_PARAM -- requirements
Module: spi_host_param

Interface
REQ-001 Parameter DATA_W, default 8, bits per transfer; legal range 1..32.
REQ-002 Parameter CLK_DIV, default 10, clk_i cycles per SCLK period; even, >=2; H = CLK_DIV/2.
REQ-003 Parameter CS_HOLD, default 3, clk_i cycles nCS stays low after last bit; >=1.
REQ-004 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 Port start_i  input  1  transfer request; accepted when start_i=1 and ready_o=1.
REQ-007 Port data_i  input  DATA_W  payload, captured at accept.
REQ-008 Port dc_i  input  1  OLED data/command flag, captured at accept.
REQ-009 Port cpol_i  input  1  clock polarity, captured at accept.
REQ-010 Port cpha_i  input  1  clock phase, captured at accept.
REQ-011 Port lsb_first_i  input  1  bit order (1 = LSB first), captured at accept.
REQ-012 Port ready_o  output  1  high only in IDLE.
REQ-013 Port done_o  output  1  one-cycle pulse on transfer completion.
REQ-014 Port ncs_o  output  1  chip select, active low.
REQ-015 Port sclk_o  output  1  serial clock.
REQ-016 Port sdo_o  output  1  serial data out.
REQ-017 Port dc_o  output  1  registered copy of captured dc_i.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, SHIFT, HOLDCS; all outputs registered except ready_o and IDLE sclk_o.
REQ-019 IDLE: ncs_o=1, sdo_o=1, sclk_o=cpol_i (live), ready_o=1; on accept -> SETUP, capture data/dc/cpol/cpha/order.
REQ-020 SETUP: lasts H cycles; ncs_o=0, sclk_o=captured cpol, sdo_o=first bit; -> SHIFT.
REQ-021 SHIFT: DATA_W bit periods of CLK_DIV cycles each; sdo_o holds bit k for its full period.
REQ-022 CPHA=0: sclk_o=cpol for first H cycles of each bit period, ~cpol for second H.
REQ-023 CPHA=1: sclk_o=~cpol for first H cycles of each bit period, cpol for second H.
REQ-024 Bit order: MSB (data[DATA_W-1]) first when lsb_first=0, data[0] first when 1.
REQ-025 HOLDCS: lasts CS_HOLD cycles; ncs_o=0, sclk_o=cpol, sdo_o=1; -> IDLE with done_o=1 in the first IDLE cycle.
REQ-026 ncs_o SHALL be low for exactly H + DATA_W*CLK_DIV + CS_HOLD cycles per transfer.
REQ-027 Bit and half-period counters SHALL wrap to 0 at terminal count; no off-by-one extra edge; exactly DATA_W leading and DATA_W trailing SCLK edges per transfer.
REQ-028 start_i while ready_o=0 SHALL be ignored, not queued; input changes after accept SHALL not affect the transfer.
REQ-029 Back-to-back: start_i held high SHALL be accepted in the done_o cycle, giving a minimum nCS-high gap of exactly 1 cycle.
REQ-030 dc_o SHALL update at accept and hold until the next accept.

Reset
REQ-031 On rst_ni=0, immediately: state IDLE, ncs_o=1, sdo_o=1, done_o=0, dc_o=0, all counters and captured registers 0; sclk_o=cpol_i.
REQ-032 Reset mid-transfer SHALL abort without done_o; first accept after release SHALL start a clean transfer.

Verification
REQ-033 Defaults, mode 0, MSB first, data 0xA5, dc=1: sdo bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges; ncs low 88 cycles; done_o one cycle after ncs rises; dc_o=1.
REQ-034 Mode 3 (cpol=1, cpha=1), data 0x3C: sclk idles high, bits launched on falling and sampled on rising edges equal 0,0,1,1,1,1,0,0.
REQ-035 lsb_first=1, data 0x01: first sampled bit 1, remaining seven 0.
REQ-036 start_i held high with two data words: two complete transfers, ncs high exactly 1 cycle between, two done_o pulses.
REQ-037 rst_ni low at cycle 40 of transfer: ncs_o=1 same cycle, no done_o; next transfer of 0xFF outputs eight 1 bits.
REQ-038 DATA_W=16, CLK_DIV=2, CS_HOLD=1, data 0x8001: 16 SCLK periods of 2 cycles, ncs low 34 cycles, first and last bits 1.
